// File: rtl/expr_gen.sv
// expr_gen: streams one random arithmetic expression "digit (op digit)*" as
// ASCII characters over a valid/ready output, driven by an 8-bit Galois LFSR.
//
// Handshake: a character transfers on a rising clk edge where
// out_valid && out_ready. out_valid, once raised, stays high and out_data
// stays stable until that transfer; out_ready may be held low for any number
// of cycles.
//
// Optional feature: define EXPR_GEN_ERR_INJECT_EN to let inj_err (sampled on
// an accepted start) replace the final digit of the stream with "?".
// Without the macro, inj_err is ignored and no injection state exists.
//
// dbg_state exposes the FSM state (0 IDLE, 1 DIGIT, 2 OP, 3 DONE).

module expr_gen (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [7:0] seed,
   input  logic [2:0] len,
   input  logic       inj_err,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       busy,
   output logic       done,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIGIT = 2'd1,
      OP    = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] lfsr;
   logic [7:0] lfsr_step;
   logic [2:0] remaining;
   logic       accept;
   logic       take_start;
   logic       inj_active;
   logic [3:0] lo_nibble;
   logic [3:0] digit_val;

   assign accept     = out_valid && out_ready;
   assign take_start = (state == IDLE) && start;
   assign dbg_state  = state;

   // Galois right-shift step with taps 8'hB8
   assign lfsr_step = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

   // Map the low nibble to a decimal digit 0..9
   assign lo_nibble = lfsr[3:0];
   assign digit_val = (lo_nibble < 4'd10) ? lo_nibble : (lo_nibble - 4'd10);

`ifdef EXPR_GEN_ERR_INJECT_EN
   logic inj_q;

   // Capture the injection request for the stream being started
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         inj_q <= 1'b0;
      end else if (take_start) begin
         inj_q <= inj_err;
      end
   end

   assign inj_active = inj_q;
`else
   logic unused_inj_err;

   assign unused_inj_err = inj_err;
   assign inj_active     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = DIGIT;
         DIGIT:   if (accept) state_next = (remaining == 3'd0) ? DONE : OP;
         OP:      if (accept) state_next = DIGIT;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // LFSR and operand counter: load on start, step only on accepted characters
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         lfsr      <= 8'h01;
         remaining <= 3'd0;
      end else if (take_start) begin
         lfsr      <= (seed == 8'h00) ? 8'h01 : seed;
         remaining <= len;
      end else begin
         if (accept) begin
            lfsr <= lfsr_step;
         end
         if ((state == OP) && accept) begin
            remaining <= remaining - 3'd1;
         end
      end
   end

   // Outputs decoded from the current state
   always_comb begin
      out_valid = 1'b0;
      out_data  = 8'h00;
      busy      = (state != IDLE);
      done      = 1'b0;
      case (state)
         DIGIT: begin
            out_valid = 1'b1;
            if (inj_active && (remaining == 3'd0)) begin
               out_data = 8'h3F;
            end else begin
               out_data = 8'h30 + {4'b0000, digit_val};
            end
         end
         OP: begin
            out_valid = 1'b1;
            out_data  = lfsr[7] ? 8'h2A : 8'h2B;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            out_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_expr_gen.sv
// Bench for expr_gen: directed scenarios plus randomized streams, checked
// against a character-level model of the expression generator.

module tb_expr_gen;

   logic       clk;
   logic       clr;
   logic       start;
   logic [7:0] seed;
   logic [2:0] len;
   logic       inj_err;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       busy;
   logic       done;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];

   expr_gen dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .seed      (seed),
      .len       (len),
      .inj_err   (inj_err),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected character sequence for one stream, from the generator rules
   function automatic void model(input logic [7:0] s, input logic [2:0] n, input logic inj);
      int l;
      int total;
      int d;
      logic [7:0] ch;
      l = (s == 8'h00) ? 1 : int'(s);
      total = 2 * int'(n) + 1;
      exp_q.delete();
      for (int i = 0; i < total; i++) begin
         if (i % 2 == 0) begin
            d = l % 16;
            if (d >= 10) d = d - 10;
            ch = 8'(48 + d);
`ifdef EXPR_GEN_ERR_INJECT_EN
            if (inj && i == total - 1) ch = 8'h3F;
`endif
         end else begin
            ch = (l >= 128) ? 8'h2A : 8'h2B;
         end
         exp_q.push_back(ch);
         if (l % 2 == 1) l = (l / 2) ^ 'hB8;
         else            l = l / 2;
      end
      if (inj) begin end
   endfunction

   // Run one full stream; stall_at < 0 selects random stalls up to stall_max
   task automatic run_stream(input logic [7:0] s, input logic [2:0] n, input logic inj,
                             input int stall_at, input int stall_n, input int stall_max);
      int ns;
      int total;
      model(s, n, inj);
      total = exp_q.size();
      check("idle_before_start", {7'b0, busy}, 8'h00);
      start = 1'b1; seed = s; len = n; inj_err = inj; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("first_valid", {7'b0, out_valid}, 8'h01);
      for (int i = 0; i < total; i++) begin
         if (stall_at >= 0) ns = (i == stall_at) ? stall_n : 0;
         else               ns = $urandom_range(0, stall_max);
         for (int k = 0; k < ns; k++) begin
            out_ready = 1'b0;
            // Noise on the start-side inputs must not disturb a busy stream
            start   = 1'($urandom_range(0, 1));
            seed    = 8'($urandom);
            len     = 3'($urandom);
            inj_err = 1'($urandom_range(0, 1));
            check("stall_valid", {7'b0, out_valid}, 8'h01);
            check("stall_data", out_data, exp_q[i]);
            @(negedge clk);
         end
         start = 1'b0;
         out_ready = 1'b1;
         check("char_valid", {7'b0, out_valid}, 8'h01);
         check("char_data", out_data, exp_q[i]);
         check("char_no_done", {7'b0, done}, 8'h00);
         @(negedge clk);
      end
      // Done cycle: a start here must be ignored
      out_ready = 1'b0;
      start = 1'b1; seed = 8'($urandom); len = 3'($urandom);
      check("done_pulse", {7'b0, done}, 8'h01);
      check("done_no_valid", {7'b0, out_valid}, 8'h00);
      check("done_data", out_data, 8'h00);
      check("done_busy", {7'b0, busy}, 8'h01);
      @(negedge clk);
      start = 1'b0;
      check("after_done", {7'b0, done}, 8'h00);
      check("after_busy", {7'b0, busy}, 8'h00);
      check("after_state", {6'b0, dbg_state}, 8'h00);
      check("after_valid", {7'b0, out_valid}, 8'h00);
      @(negedge clk);
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; seed = 8'h00; len = 3'd0; inj_err = 1'b0; out_ready = 1'b0;
      #12;
      // Reset state
      check("rst_valid", {7'b0, out_valid}, 8'h00);
      check("rst_data", out_data, 8'h00);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_done", {7'b0, done}, 8'h00);
      check("rst_state", {6'b0, dbg_state}, 8'h00);
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);

      // Single character "1"
      run_stream(8'h01, 3'd0, 1'b0, -1, 0, 0);
      // "1*2" without stalls
      run_stream(8'h01, 3'd1, 1'b0, -1, 0, 0);
      // "1*2" with "*" stalled for 3 cycles
      run_stream(8'h01, 3'd1, 1'b0, 1, 3, 0);
      // Seed 0 behaves like seed 1
      run_stream(8'h00, 3'd0, 1'b0, -1, 0, 0);
      // Error-injection request (effective only with the feature built in)
      run_stream(8'h01, 3'd1, 1'b1, -1, 0, 0);

      // Abandon a len=7 stream after 5 accepted characters
      model(8'h01, 3'd7, 1'b0);
      start = 1'b1; seed = 8'h01; len = 3'd7; inj_err = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("abort_data", out_data, exp_q[i]);
         check("abort_no_done", {7'b0, done}, 8'h00);
         @(negedge clk);
      end
      clr = 1'b1;
      #1;
      check("clr_valid", {7'b0, out_valid}, 8'h00);
      check("clr_data", out_data, 8'h00);
      check("clr_busy", {7'b0, busy}, 8'h00);
      check("clr_done", {7'b0, done}, 8'h00);
      check("clr_state", {6'b0, dbg_state}, 8'h00);
      @(negedge clk);
      clr = 1'b0;
      out_ready = 1'b0;
      check("post_clr_done", {7'b0, done}, 8'h00);
      @(negedge clk);
      run_stream(8'h01, 3'd0, 1'b0, -1, 0, 0);

      // Randomized streams with random stalls
      for (int t = 0; t < 30; t++) begin
         run_stream(8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), -1, 0, 3);
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/expr_gen.md
EXPR_GEN -- requirements
Module: expr_gen

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 The block SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port start, input, 1 bit: request generation of one expression; honoured only in IDLE.
REQ-004 The block SHALL have port seed, input, 8 bits: LFSR seed, sampled on an accepted start.
REQ-005 The block SHALL have port len, input, 3 bits: operand count minus one (1..8 operands), sampled on an accepted start.
REQ-006 The block SHALL have port inj_err, input, 1 bit: error-injection request, sampled on an accepted start (see Configuration).
REQ-007 The block SHALL have port out_ready, input, 1 bit: downstream accepts the current character.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a character.
REQ-009 The block SHALL have port out_data, output, 8 bits: ASCII character.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last character is accepted.

Function
REQ-012 The block SHALL emit the stream digit (op digit)*, with len+1 digits and len operators, i.e. 2*len+1 characters.
REQ-013 The FSM SHALL have states IDLE, DIGIT, OP and DONE.
REQ-014 IDLE with start=1 SHALL move to DIGIT, load lfsr <= (seed==0 ? 8'h01 : seed), and load remaining <= len.
REQ-015 In DIGIT on accept (out_valid&&out_ready): remaining==0 SHALL move to DONE; otherwise the FSM SHALL move to OP.
REQ-016 In OP on accept, the FSM SHALL move to DIGIT and decrement remaining.
REQ-017 DONE SHALL assert done for exactly one cycle and then move unconditionally to IDLE.
REQ-018 out_valid SHALL be 1 exactly in DIGIT and OP; the first character SHALL be valid the cycle after start.
REQ-019 In DIGIT, out_data SHALL be "0" + d, where d = lfsr[3:0] if below 10, else lfsr[3:0]-10.
REQ-020 In OP, out_data SHALL be "*" if lfsr[7]=1, else "+".
REQ-021 Outside DIGIT and OP, out_data SHALL be 8'h00.
REQ-022 On each accepted character only, the LFSR SHALL advance as Galois right shift: lfsr <= {1'b0,lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00).
REQ-023 With out_valid=1 and out_ready=0, out_data, state and lfsr SHALL hold unchanged, with no limit on stall length.
REQ-024 start SHALL be ignored while busy=1, and seed/len/inj_err changes SHALL then have no effect.
REQ-025 A start in the same cycle as done SHALL be ignored (state is DONE, not IDLE).

Reset
REQ-026 clr=1 SHALL force immediately, regardless of clk: state=IDLE, lfsr=8'h01, remaining=0, injection flag=0.
REQ-027 During and after clr: out_valid=0, out_data=8'h00, busy=0, done=0.
REQ-028 clr mid-stream SHALL abandon the expression with no done pulse; the next start SHALL begin a fresh stream.

Configuration
REQ-029 Macro EXPR_GEN_ERR_INJECT_EN defined: inj_err=1 at an accepted start SHALL replace the final digit character with "?" (8'h3F); all other characters, timing and LFSR stepping SHALL be unchanged.
REQ-030 Macro EXPR_GEN_ERR_INJECT_EN undefined: inj_err SHALL be ignored, no injection register SHALL exist, and all streams SHALL be well-formed.

Verification
REQ-031 A bench SHALL drive seed=8'h01, len=0, out_ready=1 -> one character "1" (8'h31), then done pulse the next cycle, then busy=0.
REQ-032 A bench SHALL drive seed=8'h01, len=1, out_ready=1 -> characters "1","*","2" on consecutive cycles, then done.
REQ-033 A bench SHALL drive seed=8'h01, len=1, with out_ready low 3 cycles on the "*" -> "*" held stable 4 cycles, stream still "1*2".
REQ-034 A bench SHALL drive seed=8'h00, len=0 -> "1", identical to seed 8'h01.
REQ-035 A bench SHALL start with len=7, assert clr after 5 accepted characters, then start seed=8'h01, len=0 -> no done before clr, then "1" and done.
REQ-036 With EXPR_GEN_ERR_INJECT_EN defined, a bench SHALL drive seed=8'h01, len=1, inj_err=1 -> "1","*","?" then done; with the macro undefined, the same stimulus -> "1*2".
